muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle EX ALU. It accepts one M-extension operation (opcode 0110011, func7 0000001) from the EX stage and stalls the pipeline while it runs. The operation executes as a 32-step shift-add multiply or restoring divide. It returns a registered `rd_number`/result pair with a one-cycle valid pulse, in the same form as the EX outputs.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; 0 resets the block on the next clk edge.
- start  input  1  an M op is present in EX; held high by upstream until result_valid.
- flush  input  1  kill the in-flight op; no result is produced.
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  32  operand A.
- rs2_val  input  32  operand B.
- rd_number  input  5  destination register.
- ready  output  1  state == IDLE.
- stall  output  1  combinational; start & ~result_valid.
- result_valid  output  1  registered one-cycle pulse.
- rd_number_out  output  5  registered destination; holds until the next result.
- result_out  output  32  registered result; holds until the next result.

## Operation
- States: IDLE, CALC, FINISH.
- Accept condition: start & ready & ~result_valid & ~flush.
  - On accept, latch func3, rd_number, |A|, |B| and the result sign. The step counter resets to 0.
- Signedness by op:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU/MUL: unsigned magnitudes. MUL's low 32 bits are sign-independent.
- Special cases on accept: go directly to FINISH and skip CALC.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1_val.
  - Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC performs one step per cycle for 32 cycles (counter 0..31).
  - Multiply: 64-bit shift-add into the product register.
  - Divide: one restoring step of 32-bit remainder and quotient per cycle.
  - At count 31, go to FINISH.
- FINISH:
  - Apply sign correction.
    - Product is negated if the signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Select the result: low word (MUL), high word (MULH*), quotient or remainder.
  - Register result_out and rd_number_out, and set result_valid = 1.
  - Go to IDLE.
- Arithmetic is modulo 2^32 (result) and modulo 2^64 (product). Negating 0x80000000 yields 0x80000000.
- Start while not IDLE is ignored. Upstream holds start, so the op is not lost.
- Flush:
  - In any state, go to IDLE next edge.
  - result_valid stays 0.
  - result_out and rd_number_out keep their old values.
  - Flush overrides FINISH: no pulse.
- Reset (low):
  - State goes to IDLE.
  - All registered outputs are 0: result_valid = 0, result_out = 0, rd_number_out = 0.
  - The counter is cleared.
  - This applies mid-operation as well.

## Timing
- Accept at edge k.
  - Normal latency: CALC at edges k+1..k+32, FINISH at edge k+33. result_valid is high in the cycle after edge k+33.
  - Special case: FINISH at edge k+1. result_valid is high in the cycle after edge k+1.
- stall is high from the cycle start rises through the cycle before result_valid. In the result_valid cycle stall is 0, so the pipeline advances.
- The earliest next accept is the edge following the result_valid cycle. Back-to-back M ops therefore have a throughput of one per 35 cycles (normal) or one per 3 cycles (special case).
- When not stalled, the output only changes at FINISH.
- After reset is released, ready = 1 in the first cycle.

## Structure
- Shared package `muldiv_pkg`:
  - func3 localparams for the 8 ops.
  - State enum {IDLE, CALC, FINISH}.
  - Opcode constants ALU = 7'b0110011 and ALUI = 7'b0010011.
  - FUNC7_MULDIV = 7'b0000001.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (one shift-add or restoring-subtract step). The FSM, counter, operand registers and sign fix-up live in `muldiv_seq`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (−3) -> result_out 0xFFFFFFEB; result_valid one cycle after edge k+33; stall low in that cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) by 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 by 7 -> 14. REMU same -> 2.
- DIVU 5 by 0 -> 0xFFFFFFFF. REM 5 by 0 -> 5. DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000. REM same -> 0. Each of these special cases reaches valid one cycle after edge k+1.
- Flush at CALC count 10 -> no result_valid, ready = 1 next cycle, result_out unchanged. A new MUL 3×4 accepted afterwards -> result 12.
- reset driven low at CALC count 20 -> next edge: ready = 1, result_valid = 0, result_out = 0, rd_number_out = 0. Also check: rising start during CALC is ignored, and rd_number=5 appears on rd_number_out with the result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encodings,
// FSM states, decode constants and a conditional-negate helper.
package muldiv_pkg;

  localparam int XLEN = 32;

  // func3 encodings of the M-extension ops
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Decode constants used by EX to steer an instruction here
  localparam logic [6:0] OPC_ALU      = 7'b0110011;
  localparam logic [6:0] OPC_ALUI     = 7'b0010011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_e;

  // Two's-complement negate when neg is set; -0x80000000 wraps to itself.
  function automatic logic [XLEN-1:0] cneg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential datapath. The 64-bit accumulator holds
// {product_hi, multiplier} for multiply and {remainder, dividend/quotient}
// for divide, so both algorithms shift the same register.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              div_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_acc;
  logic [2*XLEN-1:0] div_acc;
  logic              unused_diff_msb;

  // Shift-add multiply step and restoring divide step, selected by op type
  always_comb begin
    // NOTE: every variable in this block is assigned on every path before the
    // result is used; a missed branch would silently infer a latch.
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    mul_acc = {mul_sum, acc_i[XLEN-1:1]};

    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    diff    = {1'b0, rem_sh} - {2'b00, opnd_i};
    if (diff[XLEN+1]) begin
      // Borrow: divisor does not fit, restore the shifted remainder
      div_acc = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      div_acc = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end

    acc_o = div_i ? div_acc : mul_acc;
  end

  // A successful subtract always leaves a remainder below the divisor, so
  // bit XLEN of the difference is zero whenever it is used.
  assign unused_diff_msb = diff[XLEN];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer beside the EX ALU. Latches operand magnitudes
// on accept, runs 32 shift-add or restoring-divide steps, then applies sign
// correction and returns a registered result with a one-cycle valid pulse.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_number,
  output logic            ready,
  output logic            stall,
  output logic            result_valid,
  output logic [4:0]      rd_number_out,
  output logic [XLEN-1:0] result_out
);

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              accept;
  logic              a_signed;
  logic              b_signed;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              is_div;
  logic              div_zero;
  logic              div_ovf;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result_d;

  assign accept = start & (state_q == IDLE) & ~valid_q & ~flush;

  // Operand decode for the op being offered: signedness, magnitudes, special cases
  always_comb begin
    a_signed = (func3 == F3_MULH) | (func3 == F3_MULHSU) | (func3 == F3_DIV) | (func3 == F3_REM);
    b_signed = (func3 == F3_MULH) | (func3 == F3_DIV) | (func3 == F3_REM);
    sign_a   = a_signed & rs1_val[XLEN-1];
    sign_b   = b_signed & rs2_val[XLEN-1];
    mag_a    = cneg(sign_a, rs1_val);
    mag_b    = cneg(sign_b, rs2_val);
    is_div   = func3[2];
    div_zero = is_div & (rs2_val == '0);
    div_ovf  = is_div & ~func3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_val);
  end

  muldiv_step u_step (
    .div_i  (func3_q[2]),
    .opnd_i (opnd_q),
    .acc_i  (acc_q),
    .acc_o  (acc_d)
  );

  // Sign fix-up and result selection from the finished accumulator
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = cneg(neg_res_q, acc_q[XLEN-1:0]);
    rem_fix  = cneg(neg_rem_q, acc_q[2*XLEN-1:XLEN]);
    case (func3_q)
      F3_MUL:                       result_d = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result_d = quo_fix;
      default:                      result_d = rem_fix;
    endcase
  end

  // Sequencer FSM with counter, operand registers and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples values from before the edge, independent of statement order.
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (flush) begin
      // Kill the in-flight op; outputs keep their last result
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            func3_q <= func3;
            rd_q    <= rd_number;
            cnt_q   <= '0;
            if (div_zero) begin
              acc_q     <= {rs1_val, {XLEN{1'b1}}};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= FINISH;
            end else if (div_ovf) begin
              acc_q     <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= FINISH;
            end else begin
              neg_res_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              if (is_div) begin
                opnd_q <= mag_b;
                acc_q  <= {{XLEN{1'b0}}, mag_a};
              end else begin
                opnd_q <= mag_a;
                acc_q  <= {{XLEN{1'b0}}, mag_b};
              end
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          result_q <= result_d;
          rd_out_q <= rd_q;
          valid_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready         = (state_q == IDLE);
  assign stall         = start & ~valid_q;
  assign result_valid  = valid_q;
  assign rd_number_out = rd_out_q;
  assign result_out    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a table of directed vectors, a few
// model-checked random ops, and hand-written flush/reset/start sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_number;
  logic        ready;
  logic        stall;
  logic        result_valid;
  logic [4:0]  rd_number_out;
  logic [31:0] result_out;

  int          checks   = 0;
  int          failures = 0;
  sb_t         sb_q[$];
  vec_t        tbl[$];
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .flush         (flush),
    .func3         (func3),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .rd_number     (rd_number),
    .ready         (ready),
    .stall         (stall),
    .result_valid  (result_valid),
    .rd_number_out (rd_number_out),
    .result_out    (result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour of the M ops; latency 2 for special cases, 34 otherwise
  function automatic sb_t model(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    sb_t r;
    logic [63:0] p;
    logic signed [31:0] sa;
    logic signed [31:0] sb_v;
    logic dz;
    logic ovf;
    sa   = a;
    sb_v = b;
    dz   = (b == 32'd0);
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r.rd  = rd;
    r.lat = 34;
    r.res = 32'd0;
    p     = 64'd0;
    case (f3)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; r.res = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r.res = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; r.res = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; r.res = p[63:32]; end
      3'b100: begin
        if (dz) begin r.res = 32'hFFFF_FFFF; r.lat = 2; end
        else if (ovf) begin r.res = 32'h8000_0000; r.lat = 2; end
        else r.res = sa / sb_v;
      end
      3'b101: begin
        if (dz) begin r.res = 32'hFFFF_FFFF; r.lat = 2; end
        else r.res = a / b;
      end
      3'b110: begin
        if (dz) begin r.res = a; r.lat = 2; end
        else if (ovf) begin r.res = 32'd0; r.lat = 2; end
        else r.res = sa % sb_v;
      end
      default: begin
        if (dz) begin r.res = a; r.lat = 2; end
        else r.res = a % b;
      end
    endcase
    return r;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    start     = 1'b1;
    func3     = f3;
    rs1_val   = a;
    rs2_val   = b;
    rd_number = rd;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    sb_t e;
    drive(f3, a, b, rd);
    e.rd  = rd;
    e.res = exp;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Wait for result_valid (cycle count measured from the accept edge), then
  // compare against the scoreboard head and release start.
  task automatic wait_result(input int start_cyc, input string tag);
    int  cyc;
    bit  seen;
    sb_t e;
    cyc  = start_cyc;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (result_valid) seen = 1'b1;
      else if (cyc == 1) check({tag, "_stall_busy"}, 32'(stall), 32'd1);
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_stall_in_valid"}, 32'(stall), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_scoreboard: unexpected result 0x%08h", tag, result_out);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_result"}, result_out, e.res);
        check({tag, "_rd"}, 32'(rd_number_out), 32'(e.rd));
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        last_res = e.res;
        last_rd  = e.rd;
      end
    end else if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    int  seen_cnt;
    sb_t m;

    reset     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    func3     = 3'd0;
    rs1_val   = 32'd0;
    rs2_val   = 32'd0;
    rd_number = 5'd0;
    last_res  = 32'd0;
    last_rd   = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_rd", 32'(rd_number_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ready), 32'd1);

    // Directed vectors: {func3, rs1, rs2, rd, expected, latency}
    tbl.push_back('{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34});
    tbl.push_back('{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34});
    tbl.push_back('{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 34});
    tbl.push_back('{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 34});
    tbl.push_back('{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34});
    tbl.push_back('{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 34});
    tbl.push_back('{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34});
    tbl.push_back('{F3_DIVU,   32'd100,        32'd7,         5'd9,  32'd14,        34});
    tbl.push_back('{F3_REMU,   32'd100,        32'd7,         5'd10, 32'd2,         34});
    tbl.push_back('{F3_DIV,    32'd100,        32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, 34});
    tbl.push_back('{F3_REM,    32'hFFFF_FF9C,  32'd7,         5'd12, 32'hFFFF_FFFE, 34});
    tbl.push_back('{F3_DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 2});
    tbl.push_back('{F3_REM,    32'd5,          32'd0,         5'd14, 32'd5,         2});
    tbl.push_back('{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2});
    tbl.push_back('{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         2});
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat);
      wait_result(0, $sformatf("vec%0d", i));
    end

    // Random ops checked against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : $urandom;
      m  = model(f3, a, b, 5'(i + 17));
      issue(f3, a, b, m.rd, m.res, m.lat);
      wait_result(0, $sformatf("rnd%0d", i));
    end

    // Start drops and rises again with new operands during CALC: ignored
    issue(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive(F3_MUL, 32'd3, 32'd3, 5'd7);
    wait_result(5, "restart");

    // Flush at CALC count 10: no result, outputs keep last values
    drive(F3_MUL, 32'd5, 32'd6, 5'd9);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_valid", 32'(result_valid), 32'd0);
    check("flush_result_held", result_out, last_res);
    check("flush_rd_held", 32'(rd_number_out), 32'(last_rd));
    seen_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) seen_cnt++;
    end
    check("flush_no_valid", 32'(seen_cnt), 32'd0);

    // Flush while in FINISH of a special-case op: no pulse
    drive(F3_DIVU, 32'd5, 32'd0, 5'd20);
    @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_finish_valid", 32'(result_valid), 32'd0);
    check("flush_finish_result", result_out, last_res);
    @(negedge clk);
    check("flush_finish_valid2", 32'(result_valid), 32'd0);

    // A new op after the flushes completes normally
    issue(F3_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 34);
    wait_result(0, "mul_after_flush");

    // Reset at CALC count 20 clears outputs
    drive(F3_MUL, 32'd9, 32'd9, 5'd3);
    repeat (21) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", result_out, 32'd0);
    check("midrst_rd", 32'(rd_number_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(ready), 32'd1);
    check("midrst_valid_after", 32'(result_valid), 32'd0);

    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 2);
    wait_result(0, "after_reset");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
